// File: rtl/ula_pkg.sv
// Shared definitions for the ULA: datapath width, op encoding, flag bundle.
package ula_pkg;

  localparam int unsigned XLEN = 64;

  // Encoding of the `sub` input.
  typedef enum logic {
    ULA_OP_ADD = 1'b0,
    ULA_OP_SUB = 1'b1
  } ula_op_e;

  // Result flags, registered alongside res when ULA_FLAGS_EN is defined.
  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } ula_flags_t;

endpackage : ula_pkg

// File: rtl/ula_adder.sv
// Combinational WIDTH-bit adder with carry-in and carry-out: a + b + cin.
module ula_adder #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Single ripple/carry-chain add, one bit wider to capture the carry-out.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  end

endmodule : ula_adder

// File: rtl/ula_core.sv
// Registered add/subtract unit, one cycle latency, valid strobe.
// Optional macro ULA_FLAGS_EN adds registered zero/neg/carry/ovf outputs.
module ula_core
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s2,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             out_valid
`ifdef ULA_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
`endif
);

  logic             is_sub;
  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH-1:0] sum;
  logic             cout;

  logic [WIDTH-1:0] res_d, res_q;
  logic             valid_d, valid_q;

  // Subtraction reuses the adder: s1 + ~s2 + 1.
  assign is_sub = (sub == ULA_OP_SUB);
  assign b_opnd = s2 ^ {WIDTH{is_sub}};

  ula_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a   (s1),
    .b   (b_opnd),
    .cin (is_sub),
    .sum (sum),
    .cout(cout)
  );

  // Capture the sum on in_valid, otherwise hold; valid is a one-cycle strobe.
  always_comb begin
    res_d   = res_q;
    valid_d = 1'b0;
    if (in_valid) begin
      res_d   = sum;
      valid_d = 1'b1;
    end
  end

  // Result and valid registers, synchronous reset wins over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign res       = res_q;
  assign out_valid = valid_q;

`ifdef ULA_FLAGS_EN
  ula_flags_t flags_d, flags_q;

  // Flags follow the same capture/hold rule as res; ovf compares the signs
  // of the operands actually entering the adder (s1 and the possibly
  // inverted s2) against the sign of the sum.
  always_comb begin
    flags_d = flags_q;
    if (in_valid) begin
      flags_d.zero  = (sum == '0);
      flags_d.neg   = sum[WIDTH-1];
      flags_d.carry = cout;
      flags_d.ovf   = (s1[WIDTH-1] == b_opnd[WIDTH-1]) &&
                      (sum[WIDTH-1] != s1[WIDTH-1]);
    end
  end

  // Flag register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign zero  = flags_q.zero;
  assign neg   = flags_q.neg;
  assign carry = flags_q.carry;
  assign ovf   = flags_q.ovf;
`else
  // Carry-out is only consumed by the flag logic.
  logic unused_cout;
  assign unused_cout = cout;
`endif

endmodule : ula_core

// File: tb/tb_ula_core.sv
// Scoreboard testbench for ula_core (flag checks active under ULA_FLAGS_EN).
module tb_ula_core;

  localparam int unsigned W = 64;

  typedef struct {
    logic [W-1:0] res;
    logic         valid;
    logic         zero;
    logic         neg;
    logic         carry;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic         sub;
  logic [W-1:0] res;
  logic         out_valid;
`ifdef ULA_FLAGS_EN
  logic         zero, neg, carry, ovf;
`endif

  ula_core #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .s1       (s1),
    .s2       (s2),
    .sub      (sub),
    .res      (res),
    .out_valid(out_valid)
`ifdef ULA_FLAGS_EN
    ,
    .zero     (zero),
    .neg      (neg),
    .carry    (carry),
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  exp_t m;  // reference model state

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Reference model: update m per the documented rules and push the expectation.
  task automatic model_step(input logic r, input logic iv, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic sb);
    logic [W:0] full;
    if (r) begin
      m.res = '0; m.valid = 1'b0;
      m.zero = 1'b0; m.neg = 1'b0; m.carry = 1'b0; m.ovf = 1'b0;
    end else if (iv) begin
      if (sb) begin
        m.res   = a - b;
        m.carry = (a >= b);
        m.ovf   = (a[W-1] != b[W-1]) && (m.res[W-1] != a[W-1]);
      end else begin
        full    = {1'b0, a} + {1'b0, b};
        m.res   = full[W-1:0];
        m.carry = full[W];
        m.ovf   = (a[W-1] == b[W-1]) && (m.res[W-1] != a[W-1]);
      end
      m.zero  = (m.res == '0);
      m.neg   = m.res[W-1];
      m.valid = 1'b1;
    end else begin
      m.valid = 1'b0;
    end
    sb_q.push_back(m);
  endtask

  // Drive one cycle of stimulus, then compare the DUT against the scoreboard head.
  task automatic cycle(input logic r, input logic iv, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic sb);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = iv; s1 = a; s2 = b; sub = sb;
    model_step(r, iv, a, b, sb);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check("res", res, e.res);
      check("out_valid", {63'd0, out_valid}, {63'd0, e.valid});
`ifdef ULA_FLAGS_EN
      check("zero",  {63'd0, zero},  {63'd0, e.zero});
      check("neg",   {63'd0, neg},   {63'd0, e.neg});
      check("carry", {63'd0, carry}, {63'd0, e.carry});
      check("ovf",   {63'd0, ovf},   {63'd0, e.ovf});
`endif
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b0; in_valid = 1'b0; s1 = '0; s2 = '0; sub = 1'b0;
    m = '{res: '0, valid: 1'b0, zero: 1'b0, neg: 1'b0, carry: 1'b0, ovf: 1'b0};

    // Reset state
    cycle(1'b1, 1'b0, 64'd0, 64'd0, 1'b0);
    cycle(1'b1, 1'b0, 64'd0, 64'd0, 1'b0);
    check("rst_res_const", res, 64'd0);

    // Basic add / subtract with fixed expectations as well as the model
    cycle(1'b0, 1'b1, 64'd450, 64'd47, 1'b0);
    check("add_const", res, 64'd497);
    cycle(1'b0, 1'b1, 64'd450, 64'd47, 1'b1);
    check("sub_const", res, 64'd403);

    // Wrap and negative
    cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    check("wrap_const", res, 64'd0);
    cycle(1'b0, 1'b1, 64'd0, 64'd1, 1'b1);
    check("neg_const", res, 64'hFFFF_FFFF_FFFF_FFFF);

    // Signed overflow both directions
    cycle(1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    check("ovf_add_const", res, 64'h8000_0000_0000_0000);
    cycle(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    check("ovf_sub_const", res, 64'h7FFF_FFFF_FFFF_FFFF);

    // Equal operands subtract: zero with carry set
    cycle(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1);

    // Hold: result stays while in_valid is low and operands change
    cycle(1'b0, 1'b1, 64'd450, 64'd47, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 64'd1, 64'd2, 1'b1);
      check("hold_const", res, 64'd497);
    end

    // Reset priority over in_valid, then resume
    cycle(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    cycle(1'b1, 1'b1, 64'd5, 64'd6, 1'b0);
    check("rst_prio_const", res, 64'd0);
    cycle(1'b0, 1'b1, 64'd5, 64'd6, 1'b0);
    check("resume_const", res, 64'd11);

    // Back-to-back and sparse random traffic
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, ($urandom_range(0, 3) != 0),
            {$urandom(), $urandom()}, {$urandom(), $urandom()},
            $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ula_core
